// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg: FSM states, SPI mode encodings and default sizes for master_spi_param
// Revision: 1.0
// ============================================================================
package spi_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV   = 4;
  localparam int DEF_NCS   = 4;

  // Mode index is {Cpol, Cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    HOLD   = 3'd3,
    FINISH = 3'd4
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_tick_div.sv
`default_nettype none
// ============================================================================
// spi_tick_div: free-running DIV-cycle half-period counter with clear and tick
// Revision: 1.0
// ============================================================================
module spi_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !clear && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/master_spi_param.sv
`default_nettype none
// ============================================================================
// master_spi_param: SPI master, configurable width/rate/selects, modes 0-3
// Revision: 1.0
// ============================================================================
module master_spi_param
  import spi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV,
  parameter int NCS   = DEF_NCS,
  parameter int SELW  = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Go,
  input  logic [WIDTH-1:0] Tx_word,
  input  logic [SELW-1:0]  Cs_sel,
  input  logic             Cpol,
  input  logic             Cpha,
  output logic [WIDTH-1:0] Rx_word,
  output logic             Busy,
  output logic             Done,
  output logic [NCS-1:0]   CS,
  output logic             SCK,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  spi_state_t       state, state_n;
  logic             cpol_q, cpol_n, cpha_q, cpha_n;
  logic [SELW-1:0]  sel_q, sel_n;
  logic [WIDTH-1:0] tx_q, tx_n, rx_q, rx_n, rx_word_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic             half_q, half_n;
  logic             sck_n, mosi_n, busy_n, done_n, xfer_active;
  logic [NCS-1:0]   cs_n;
  logic             idle, tick, lead_edge, trail_edge;

  assign idle = (state == IDLE);

  spi_tick_div #(.DIV(DIV)) u_tick (
    .clk   (CLK),
    .rst   (RST),
    .clear (idle),
    .tick  (tick)
  );

  // half_q marks that the next SCK edge is the trailing one of the current bit
  assign lead_edge  = tick && ((state == SETUP) || ((state == SHIFT) && !half_q));
  assign trail_edge = tick && (state == SHIFT) && half_q;

  always_comb begin
    state_n   = state;
    cpol_n    = cpol_q;
    cpha_n    = cpha_q;
    sel_n     = sel_q;
    tx_n      = tx_q;
    rx_n      = rx_q;
    bit_n     = bit_q;
    half_n    = half_q;
    sck_n     = SCK;
    mosi_n    = MOSI;
    rx_word_n = Rx_word;

    case (state)
      IDLE: begin
        sck_n  = cpol_q;
        mosi_n = 1'b1;
        if (Go) begin
          state_n = SETUP;
          cpol_n  = Cpol;
          cpha_n  = Cpha;
          sel_n   = Cs_sel;
          tx_n    = Tx_word;
          rx_n    = '0;
          bit_n   = '0;
          half_n  = 1'b0;
          sck_n   = Cpol;
          mosi_n  = Cpha ? 1'b1 : Tx_word[WIDTH-1];
        end
      end
      SETUP: if (tick) state_n = SHIFT;
      SHIFT: if (trail_edge && (bit_q == LAST_BIT)) state_n = HOLD;
      HOLD: begin
        if (tick) begin
          state_n   = FINISH;
          mosi_n    = 1'b1;
          rx_word_n = rx_q;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (lead_edge) begin
      sck_n  = ~SCK;
      half_n = 1'b1;
      if (!cpha_q) begin
        rx_n = {rx_q[WIDTH-2:0], MISO};
      end else begin
        mosi_n = tx_q[WIDTH-1];
        tx_n   = tx_q << 1;
      end
    end

    if (trail_edge) begin
      sck_n  = ~SCK;
      half_n = 1'b0;
      if (cpha_q) begin
        rx_n = {rx_q[WIDTH-2:0], MISO};
      end else if (bit_q != LAST_BIT) begin
        mosi_n = tx_q[WIDTH-2];
        tx_n   = tx_q << 1;
      end
      if (bit_q != LAST_BIT) bit_n = bit_q + 1'b1;
    end

    xfer_active = (state_n == SETUP) || (state_n == SHIFT) || (state_n == HOLD);
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == FINISH);
    // An out-of-range select leaves every line deasserted
    cs_n        = '1;
    for (int i = 0; i < NCS; i++) begin
      if (xfer_active && (int'(sel_n) == i)) cs_n[i] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sel_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      Rx_word <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      CS      <= '1;
      SCK     <= 1'b0;
      MOSI    <= 1'b1;
    end else begin
      state   <= state_n;
      cpol_q  <= cpol_n;
      cpha_q  <= cpha_n;
      sel_q   <= sel_n;
      tx_q    <= tx_n;
      rx_q    <= rx_n;
      bit_q   <= bit_n;
      half_q  <= half_n;
      Rx_word <= rx_word_n;
      Busy    <= busy_n;
      Done    <= done_n;
      CS      <= cs_n;
      SCK     <= sck_n;
      MOSI    <= mosi_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_master_spi_param.sv
`default_nettype none
// ============================================================================
// tb_master_spi_param: table-driven and scoreboard bench for master_spi_param
// Revision: 1.0
// ============================================================================
module tb_master_spi_param;
  import spi_pkg::*;

  localparam int WA = 16, DA = 4, NA = 4, SA = 3;
  localparam int WB = 8,  DB = 2, NB = 1, SB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          go_a, cpol_a, cpha_a, busy_a, done_a, sck_a, mosi_a, miso_a, loop_a;
  logic [WA-1:0] tx_a, rx_word_a;
  logic [SA-1:0] sel_a;
  logic [NA-1:0] cs_a;

  logic          go_b, cpol_b, cpha_b, busy_b, done_b, sck_b, mosi_b, miso_b;
  logic [WB-1:0] tx_b, rx_word_b;
  logic [SB-1:0] sel_b;
  logic [NB-1:0] cs_b;

  master_spi_param #(.WIDTH(WA), .DIV(DA), .NCS(NA), .SELW(SA)) dut_a (
    .CLK(clk), .RST(rst), .Go(go_a), .Tx_word(tx_a), .Cs_sel(sel_a), .Cpol(cpol_a),
    .Cpha(cpha_a), .Rx_word(rx_word_a), .Busy(busy_a), .Done(done_a), .CS(cs_a),
    .SCK(sck_a), .MOSI(mosi_a), .MISO(miso_a));

  master_spi_param #(.WIDTH(WB), .DIV(DB), .NCS(NB), .SELW(SB)) dut_b (
    .CLK(clk), .RST(rst), .Go(go_b), .Tx_word(tx_b), .Cs_sel(sel_b), .Cpol(cpol_b),
    .Cpha(cpha_b), .Rx_word(rx_word_b), .Busy(busy_b), .Done(done_b), .CS(cs_b),
    .SCK(sck_b), .MOSI(mosi_b), .MISO(miso_b));

  assign miso_b = mosi_b;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural slave on CS[2]: answers slv_resp and records what it receives
  logic [15:0] slv_resp = 16'h0, slv_cap = 16'h0;
  logic        slv_cpol = 1'b0, slv_cpha = 1'b0, slv_miso = 1'b0;
  logic        slv_prev_cs = 1'b1, slv_prev_sck = 1'b0;
  int          slv_idx = 15;

  assign miso_a = loop_a ? mosi_a : slv_miso;

  always @(sck_a or cs_a[2]) begin
    if (cs_a[2]) begin
      slv_prev_cs = 1'b1;
    end else if (slv_prev_cs) begin
      slv_prev_cs  = 1'b0;
      slv_prev_sck = slv_cpol;
      slv_idx      = 15;
      slv_cap      = 16'h0;
      if (!slv_cpha) slv_miso = slv_resp[15];
    end else if (sck_a !== slv_prev_sck) begin
      slv_prev_sck = sck_a;
      if (sck_a !== slv_cpol) begin
        if (!slv_cpha) slv_cap = {slv_cap[14:0], mosi_a};
        else if (slv_idx >= 0) slv_miso = slv_resp[slv_idx];
      end else begin
        if (slv_cpha) slv_cap = {slv_cap[14:0], mosi_a};
        slv_idx--;
        if (!slv_cpha && slv_idx >= 0) slv_miso = slv_resp[slv_idx];
      end
    end
  end

  typedef struct {
    logic [63:0] rx;
    int          cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   done_cnt_a = 0, done_cnt_b = 0;

  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      done_cnt_a++;
      if (sb_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done_a: got Done=1, expected no Done (cycle %0d)", cyc);
      end else begin
        e = sb_a.pop_front();
        check("rx_word_a", 64'(rx_word_a), e.rx);
        check("done_cycle_a", 64'(cyc), 64'(e.cyc));
      end
    end
    if (done_b) begin
      done_cnt_b++;
      if (sb_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done_b: got Done=1, expected no Done (cycle %0d)", cyc);
      end else begin
        e = sb_b.pop_front();
        check("rx_word_b", 64'(rx_word_b), e.rx);
        check("done_cycle_b", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] tx;
    logic [2:0]  sel;
    logic        loop;
    logic [15:0] resp;
    logic [15:0] exp_rx;
    logic [3:0]  exp_cs;
  } vec_t;

  vec_t vecs [7];

  // Starts on a negedge; returns on the first negedge with Busy low
  task automatic xfer_a(input vec_t v);
    exp_t e;
    int   rises, cs_err, d0;
    logic prev, ended;
    loop_a   = v.loop;
    slv_resp = v.resp;
    slv_cpol = v.mode[1];
    slv_cpha = v.mode[0];
    tx_a     = v.tx;
    sel_a    = v.sel;
    cpol_a   = v.mode[1];
    cpha_a   = v.mode[0];
    go_a     = 1'b1;
    e.rx     = 64'(v.exp_rx);
    e.cyc    = cyc + 1 + (2 * WA + 1) * DA;
    sb_a.push_back(e);
    d0 = done_cnt_a;
    @(negedge clk);
    go_a = 1'b0;
    check("busy_start", 64'(busy_a), 64'(1));
    check("cs_start", 64'(cs_a), 64'(v.exp_cs));
    check("sck_setup_is_cpol", 64'(sck_a), 64'(v.mode[1]));
    prev   = sck_a;
    rises  = 0;
    cs_err = 0;
    ended  = 1'b0;
    for (int i = 0; i < 400 && !ended; i++) begin
      @(negedge clk);
      if (sck_a && !prev) rises++;
      prev = sck_a;
      if (!busy_a) ended = 1'b1;
      else if (!done_a && cs_a !== v.exp_cs) cs_err++;
    end
    check("xfer_completes", 64'(ended), 64'(1));
    check("cs_held", 64'(cs_err), 64'(0));
    check("sck_rising_edges", 64'(rises), 64'(16));
    check("sck_idle_is_cpol", 64'(sck_a), 64'(v.mode[1]));
    check("cs_idle", 64'(cs_a), 64'(4'hF));
    check("done_count", 64'(done_cnt_a - d0), 64'(1));
    if (!v.loop) check("slave_capture", 64'(slv_cap), 64'(v.tx));
  endtask

  task automatic xfer_b(input logic [7:0] tx, input logic [1:0] mode);
    exp_t e;
    logic ended;
    tx_b   = tx;
    sel_b  = 1'b0;
    cpol_b = mode[1];
    cpha_b = mode[0];
    go_b   = 1'b1;
    e.rx   = 64'(tx);
    e.cyc  = cyc + 1 + (2 * WB + 1) * DB;
    sb_b.push_back(e);
    @(negedge clk);
    go_b = 1'b0;
    check("cs_b_start", 64'(cs_b), 64'(0));
    ended = 1'b0;
    for (int i = 0; i < 200 && !ended; i++) begin
      @(negedge clk);
      if (!busy_b) ended = 1'b1;
    end
    check("xfer_b_completes", 64'(ended), 64'(1));
    check("sck_b_idle", 64'(sck_b), 64'(mode[1]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   d0, m;
    logic ended;

    vecs[0] = '{MODE0, 16'hA5C3, 3'd2, 1'b1, 16'h0000, 16'hA5C3, 4'b1011};
    vecs[1] = '{MODE1, 16'h1234, 3'd2, 1'b0, 16'h3C96, 16'h3C96, 4'b1011};
    vecs[2] = '{MODE2, 16'h1234, 3'd2, 1'b0, 16'h3C96, 16'h3C96, 4'b1011};
    vecs[3] = '{MODE3, 16'h1234, 3'd2, 1'b0, 16'h3C96, 16'h3C96, 4'b1011};
    vecs[4] = '{MODE0, 16'h1234, 3'd2, 1'b0, 16'h3C96, 16'h3C96, 4'b1011};
    vecs[5] = '{MODE0, 16'hF00F, 3'd5, 1'b1, 16'h0000, 16'hF00F, 4'b1111};
    vecs[6] = '{MODE3, 16'h8001, 3'd0, 1'b1, 16'h0000, 16'h8001, 4'b1110};

    rst = 1'b1;
    go_a = 1'b0; tx_a = '0; sel_a = '0; cpol_a = 1'b0; cpha_a = 1'b0; loop_a = 1'b1;
    go_b = 1'b0; tx_b = '0; sel_b = '0; cpol_b = 1'b0; cpha_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(cs_a), 64'(4'hF));
    check("rst_sck", 64'(sck_a), 64'(0));
    check("rst_mosi", 64'(mosi_a), 64'(1));
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_done", 64'(done_a), 64'(0));
    check("rst_rx", 64'(rx_word_a), 64'(0));
    check("rst_cs_b", 64'(cs_b), 64'(1));
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) xfer_a(vecs[i]);

    // Go pulses, Tx and mode churn while Busy; the first word must go out untouched
    loop_a = 1'b1; tx_a = 16'h5AA5; sel_a = 3'd1; cpol_a = 1'b0; cpha_a = 1'b0; go_a = 1'b1;
    e.rx  = 64'h5AA5;
    e.cyc = cyc + 1 + (2 * WA + 1) * DA;
    sb_a.push_back(e);
    d0 = done_cnt_a;
    @(negedge clk);
    ended = 1'b0;
    for (int i = 0; i < 400 && !ended; i++) begin
      go_a   = 1'($urandom_range(0, 1));
      tx_a   = 16'($urandom);
      cpol_a = 1'($urandom_range(0, 1));
      cpha_a = 1'($urandom_range(0, 1));
      sel_a  = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (!busy_a) ended = 1'b1;
    end
    check("noisy_xfer_completes", 64'(ended), 64'(1));
    check("noisy_done_count", 64'(done_cnt_a - d0), 64'(1));
    // Back-to-back Go on the first Busy-low cycle
    xfer_a('{MODE1, 16'h0FF0, 3'd1, 1'b1, 16'h0000, 16'h0FF0, 4'b1101});

    // Reset at the clock edge that would make SCK edge 7 (mode 2, idle high)
    loop_a = 1'b1; tx_a = 16'hC3C3; sel_a = 3'd0; cpol_a = 1'b1; cpha_a = 1'b0; go_a = 1'b1;
    m = cyc;
    d0 = done_cnt_a;
    @(negedge clk);
    go_a = 1'b0;
    while (cyc < m + 28) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs", 64'(cs_a), 64'(4'hF));
    check("abort_sck", 64'(sck_a), 64'(0));
    check("abort_mosi", 64'(mosi_a), 64'(1));
    check("abort_busy", 64'(busy_a), 64'(0));
    check("abort_done", 64'(done_a), 64'(0));
    check("abort_rx", 64'(rx_word_a), 64'(0));
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_no_done", 64'(done_cnt_a - d0), 64'(0));
    check("abort_rx_stable", 64'(rx_word_a), 64'(0));

    // Small configuration: WIDTH=8, DIV=2, NCS=1
    xfer_b(8'h81, MODE0);
    xfer_b(8'h3C, MODE3);
    xfer_b(8'hB6, MODE1);
    check("done_count_b", 64'(done_cnt_b), 64'(3));

    repeat (4) @(negedge clk);
    check("scoreboard_a_empty", 64'(sb_a.size()), 64'(0));
    check("scoreboard_b_empty", 64'(sb_b.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
